// File: rtl/riscv_defines.sv
// riscv_defines: shared ALU operator encodings and divider state/decode constants.
package riscv_defines;
   localparam int ALU_OP_WIDTH = 7;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;
   localparam int DIV_OP_SIGNED_BIT = 0;
   localparam int DIV_OP_REM_BIT    = 1;
   typedef enum logic [1:0] {DIV_IDLE, DIV_DIVIDE, DIV_FINISH} div_state_t;
endpackage

// File: rtl/riscv_serdiv_step.sv
// riscv_serdiv_step: one restoring-division iteration (shift, compare, conditional subtract).
module riscv_serdiv_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quot,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quot_next
);
   // One extra bit keeps the shifted remainder exact when the divisor uses the full width.
   logic [WIDTH:0] shifted;
   logic           ge;
   always_comb begin
      shifted   = {rem, quot[WIDTH-1]};
      ge        = shifted >= {1'b0, divisor};
      rem_next  = ge ? shifted[WIDTH-1:0] - divisor : shifted[WIDTH-1:0];
      quot_next = {quot[WIDTH-2:0], ge};
   end
endmodule

// File: rtl/riscv_serdiv_param.sv
// riscv_serdiv_param: serial restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle,
// valid/ready on both sides, kill flush and divide-by-zero early-out.
module riscv_serdiv_param
   import riscv_defines::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    kill_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [ALU_OP_WIDTH-1:0] operator_i,
   input  logic [WIDTH-1:0]        op_a_i,
   input  logic [WIDTH-1:0]        op_b_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [WIDTH-1:0]        result_o
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             is_signed, is_rem, a_neg, b_neg, out_valid;
   logic [WIDTH-1:0] rem, quot, b_abs, result;
   logic [WIDTH-1:0] rem_next, quot_next, result_fix;
   logic             sgn_in, a_neg_in, b_neg_in, unused_op;

   assign in_ready_o  = state == DIV_IDLE;
   assign out_valid_o = out_valid;
   assign result_o    = result;
   assign sgn_in      = operator_i[DIV_OP_SIGNED_BIT];
   assign a_neg_in    = sgn_in & op_a_i[WIDTH-1];
   assign b_neg_in    = sgn_in & op_b_i[WIDTH-1];
   assign unused_op   = ^operator_i[ALU_OP_WIDTH-1:2];

   riscv_serdiv_step #(.WIDTH(WIDTH)) u_step (
      .rem       (rem),
      .quot      (quot),
      .divisor   (b_abs),
      .rem_next  (rem_next),
      .quot_next (quot_next)
   );

   always_comb
      result_fix = is_rem ? ((is_signed & a_neg) ? -rem_next : rem_next)
                          : ((is_signed & (a_neg ^ b_neg)) ? -quot_next : quot_next);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= DIV_IDLE;
         cnt       <= '0;
         is_signed <= 1'b0;
         is_rem    <= 1'b0;
         a_neg     <= 1'b0;
         b_neg     <= 1'b0;
         rem       <= '0;
         quot      <= '0;
         b_abs     <= '0;
         result    <= '0;
         out_valid <= 1'b0;
      end else if (kill_i) begin
         state     <= DIV_IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: if (in_valid_i) begin
               is_signed <= sgn_in;
               is_rem    <= operator_i[DIV_OP_REM_BIT];
               a_neg     <= a_neg_in;
               b_neg     <= b_neg_in;
               quot      <= a_neg_in ? -op_a_i : op_a_i;
               b_abs     <= b_neg_in ? -op_b_i : op_b_i;
               rem       <= '0;
               cnt       <= CNT_W'(WIDTH);
               // Zero divisor skips iteration; RISC-V defines the result directly.
               if (op_b_i == '0) begin
                  state     <= DIV_FINISH;
                  out_valid <= 1'b1;
                  result    <= operator_i[DIV_OP_REM_BIT] ? op_a_i : '1;
               end else
                  state <= DIV_DIVIDE;
            end
            DIV_DIVIDE: begin
               rem  <= rem_next;
               quot <= quot_next;
               cnt  <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state     <= DIV_FINISH;
                  out_valid <= 1'b1;
                  result    <= result_fix;
               end
            end
            DIV_FINISH: if (out_ready_i) begin
               state     <= DIV_IDLE;
               out_valid <= 1'b0;
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_riscv_serdiv_param.sv
// tb_riscv_serdiv_param: random and directed checks of 32- and 8-bit dividers against an arithmetic model.
module tb_riscv_serdiv_param;
   import riscv_defines::*;

   logic clk = 0, rst = 1, kill = 0, out_ready = 0;
   logic iv32 = 0, iv8 = 0;
   logic [ALU_OP_WIDTH-1:0] op = ALU_DIVU;
   logic [31:0] a = 0, b = 0;
   logic ir32, ir8, ov32, ov8;
   logic [31:0] r32;
   logic [7:0] r8;
   int n_chk = 0, n_fail = 0;
   logic [ALU_OP_WIDTH-1:0] ops [4] = '{ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM};

   always #5 clk = ~clk;

   riscv_serdiv_param #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .kill_i(kill), .in_valid_i(iv32), .in_ready_o(ir32),
      .operator_i(op), .op_a_i(a), .op_b_i(b), .out_valid_o(ov32),
      .out_ready_i(out_ready), .result_o(r32));

   riscv_serdiv_param #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .kill_i(kill), .in_valid_i(iv8), .in_ready_o(ir8),
      .operator_i(op), .op_a_i(a[7:0]), .op_b_i(b[7:0]), .out_valid_o(ov8),
      .out_ready_i(out_ready), .result_o(r8));

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_res(logic [1:0] o, logic [63:0] x, logic [63:0] y, int w);
      logic [63:0] m = (64'd1 << w) - 1;
      longint sx, sy, q, r;
      x &= m;
      y &= m;
      if (y == 0) return o[1] ? x : m;
      if (o[0]) begin
         sx = $signed(x << (64 - w)) >>> (64 - w);
         sy = $signed(y << (64 - w)) >>> (64 - w);
      end else begin
         sx = x;
         sy = y;
      end
      q = sx / sy;
      r = sx % sy;
      return (o[1] ? r : q) & m;
   endfunction

   task automatic run_op(int w, logic [ALU_OP_WIDTH-1:0] o, logic [31:0] x, logic [31:0] y,
                         int hold, string tag);
      logic [63:0] exp = ref_res(o[1:0], x, y, w);
      logic [63:0] ym = y & ((64'd1 << w) - 1);
      int exp_lat = (ym == 0) ? 1 : w + 1;
      int lat;
      logic [63:0] first;
      @(negedge clk);
      op = o; a = x; b = y;
      if (w == 8) iv8 = 1; else iv32 = 1;
      chk({tag, " in_ready"}, w == 8 ? ir8 : ir32, 1);
      @(posedge clk);
      @(negedge clk);
      iv8 = 0; iv32 = 0;
      a = $urandom; b = $urandom;
      lat = 1;
      while (!(w == 8 ? ov8 : ov32) && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, lat, exp_lat);
      first = w == 8 ? {56'd0, r8} : {32'd0, r32};
      chk({tag, " result"}, first, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, " hold result"}, w == 8 ? {56'd0, r8} : {32'd0, r32}, first);
         chk({tag, " hold valid"}, w == 8 ? ov8 : ov32, 1);
         chk({tag, " hold in_ready"}, w == 8 ? ir8 : ir32, 0);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk({tag, " valid drop"}, w == 8 ? ov8 : ov32, 0);
      chk({tag, " ready back"}, w == 8 ? ir8 : ir32, 1);
   endtask

   initial begin
      int seen, lat;
      logic [31:0] x, y;
      #2;
      chk("reset in_ready32", ir32, 1);
      chk("reset out_valid32", ov32, 0);
      chk("reset result32", r32, 0);
      chk("reset in_ready8", ir8, 1);
      repeat (2) @(negedge clk);
      rst = 0;

      run_op(32, ALU_DIVU, 100, 7, 0, "divu 100/7");
      run_op(32, ALU_REM, 32'hFFFFFF9C, 7, 0, "rem -100/7");
      run_op(32, ALU_DIV, 32'hFFFFFF9C, 7, 0, "div -100/7");
      run_op(32, ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, "div min/-1");
      run_op(32, ALU_REM, 32'h80000000, 32'hFFFFFFFF, 0, "rem min/-1");
      run_op(32, ALU_DIV, 5, 0, 0, "div 5/0");
      run_op(32, ALU_REMU, 5, 0, 0, "remu 5/0");
      run_op(32, ALU_REM, 32'hFFFFFFFB, 0, 0, "rem -5/0");
      run_op(8, ALU_DIVU, 8'hFF, 8'h10, 5, "w8 divu ff/10");

      // Flush mid-divide while a new request is presented.
      @(negedge clk);
      op = ALU_DIVU; a = 1000; b = 7; iv32 = 1;
      @(posedge clk);
      @(negedge clk);
      iv32 = 0;
      repeat (9) @(negedge clk);
      kill = 1; iv32 = 1; a = 9; b = 3;
      @(posedge clk);
      @(negedge clk);
      kill = 0; iv32 = 0;
      chk("kill in_ready", ir32, 1);
      chk("kill out_valid", ov32, 0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (ov32) seen++;
      end
      chk("kill no result", seen, 0);
      kill = 1; iv32 = 1;
      @(negedge clk);
      kill = 0; iv32 = 0;
      chk("kill idle no accept", ir32, 1);
      run_op(32, ALU_DIVU, 9, 3, 0, "after kill 9/3");

      // Reset while a result is waiting discards it.
      @(negedge clk);
      op = ALU_DIV; a = 77; b = 5; iv32 = 1;
      @(negedge clk);
      iv32 = 0;
      lat = 0;
      while (!ov32 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("pre-reset valid", ov32, 1);
      rst = 1;
      #1;
      chk("mid reset valid", ov32, 0);
      chk("mid reset result", r32, 0);
      chk("mid reset ready", ir32, 1);
      @(negedge clk);
      rst = 0;

      for (int i = 0; i < 40; i++) begin
         x = $urandom;
         case ($urandom_range(4))
            0: y = 0;
            1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            2: y = $urandom_range(1, 20);
            3: y = -$urandom_range(1, 20);
            default: y = $urandom;
         endcase
         run_op(32, ops[$urandom_range(3)], x, y, $urandom_range(2), "rand32");
      end
      for (int i = 0; i < 30; i++) begin
         x = $urandom;
         y = ($urandom_range(5) == 0) ? 0 : $urandom;
         run_op(8, ops[$urandom_range(3)], x, y, $urandom_range(2), "rand8");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/riscv_serdiv_param.md
Name: riscv_serdiv_param

Overview:
- Parametrised sequential restoring divider for the ALU_DIVU / ALU_DIV / ALU_REMU / ALU_REM operations, one quotient bit per cycle.
- Sits beside the ALU in the EX stage.
- Width is a parameter. Adds a valid/ready handshake on both sides, a kill/flush input and a divide-by-zero early-out.
- Operation is decoded from the existing ALU operator encoding: bit 0 = signed, bit 1 = remainder.

Parameters:
- WIDTH, 32, operand and result width in bits (legal values 8..64).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- kill_i  in  1  abort the current operation (pipeline flush).
- in_valid_i  in  1  operands and operator valid.
- in_ready_o  out  1  divider can accept a new operation.
- operator_i  in  ALU_OP_WIDTH  one of ALU_DIVU/DIV/REMU/REM; other values are illegal.
- op_a_i  in  WIDTH  dividend.
- op_b_i  in  WIDTH  divisor.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- result_o  out  WIDTH  quotient or remainder.

Behaviour:
- Reset (async, rst=1): state IDLE, out_valid_o=0, result_o=0, counter=0, all datapath registers 0. in_ready_o=1 while in reset.
- in_ready_o = (state==IDLE), combinational.
- State IDLE:
  - Accept occurs when in_valid_i && in_ready_o && !kill_i.
  - On accept, latch the operator bits, a_neg = signed & a[MSB] and b_neg = signed & b[MSB].
  - Latch |a| and |b|, negating a if a_neg and b if b_neg.
  - Clear the partial remainder and load counter = WIDTH.
  - If op_b_i==0, go to FINISH with the zero-divide result. Otherwise go to DIVIDE.
- State DIVIDE, once per cycle:
  - Shift {rem, quot} left by one, bringing in the quotient MSB.
  - If the shifted remainder >= |b|, subtract |b| and set quotient LSB to 1.
  - Decrement counter. When counter reaches 1, the cycle completing the last step moves to FINISH.
  - The output register is loaded on the same edge with the sign-corrected value:
    - quotient is negated if signed & (a_neg ^ b_neg);
    - remainder is negated if signed & a_neg.
- State FINISH:
  - out_valid_o=1 and result_o is stable.
  - On out_ready_i, go to IDLE with out_valid_o=0. The next op is accepted no earlier than the following cycle.
- Latency from the accept edge to the first cycle with out_valid_o=1 is WIDTH+1 cycles (normal) or 1 cycle (divide by zero). Each accept yields exactly one result.
- Divide by zero, per the RISC-V spec:
  - quotient is all ones, for both signed and unsigned;
  - remainder is op_a_i unmodified.
  - No sign correction is applied.
- Signed overflow (MIN / -1): quotient = MIN and remainder = 0. This falls out of the magnitude datapath and needs no special case.
- kill_i, in any state: next state IDLE, out_valid_o=0 and the counter is cleared. kill_i takes priority over in_valid_i and over out_ready_i.
- Reset asserted mid-operation: the block returns to reset values immediately and the result is discarded.
- In FINISH with out_ready_i=0, result_o and out_valid_o hold indefinitely.
- Illegal operator values are treated as ALU_DIVU (bits [1:0] decoded only). No error is flagged.

Decomposition:
- ALU_DIV* encodings and ALU_OP_WIDTH stay in riscv_defines.
- Add to riscv_defines:
  - localparam-style constants DIV_OP_SIGNED_BIT=0 and DIV_OP_REM_BIT=1;
  - typedef enum logic [1:0] {DIV_IDLE, DIV_DIVIDE, DIV_FINISH} div_state_t.
- One sub-module, riscv_serdiv_step: combinational single-iteration shift/compare/subtract, WIDTH-parametrised, instantiated once.

Test Plan:
- WIDTH=32, DIVU, a=100, b=7 -> result 14, out_valid_o exactly 33 cycles after accept.
- WIDTH=32, REM, a=-100 (0xFFFFFF9C), b=7 -> result -2 (0xFFFFFFFE). Same inputs with DIV -> -14 (0xFFFFFFF2).
- WIDTH=32, DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM with the same inputs -> 0.
- WIDTH=32, DIV a=5, b=0 -> 0xFFFFFFFF one cycle after accept. REMU a=5, b=0 -> 5.
- Accept DIVU, assert kill_i at cycle 10 with in_valid_i=1 -> no accept that cycle, IDLE next cycle, no out_valid_o. The following op 9/3 -> 3.
- WIDTH=8 build: DIVU a=0xFF, b=0x10 -> 0x0F at 9 cycles. Hold out_ready_i=0 for 5 cycles -> result_o and out_valid_o stable, in_ready_o=0 throughout.
